// File: rtl/sram_bus_bridge_pkg.sv
// rtl/sram_bus_bridge_pkg.sv - shared widths, FSM state encoding and address helper for the SRAM bridge
package sram_bus_bridge_pkg;

    localparam int CPU_ADR_W  = 16;
    localparam int SRAM_ADR_W = 18;
    localparam int DATA_W     = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } bridge_state_t;

    function automatic logic [SRAM_ADR_W-1:0] sram_adr(input logic [1:0] hi,
                                                       input logic [CPU_ADR_W-1:0] adr);
        return {hi, adr};
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable wait-state down-counter with zero flag
module sram_wait_counter
    import sram_bus_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  dec,
    input  logic [WAIT_CNT_W-1:0] load_value,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_bus_bridge.sv
// rtl/sram_bus_bridge.sv - CPU to asynchronous SRAM bridge with registered strobes and wait states
module sram_bus_bridge
    import sram_bus_bridge_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter logic [1:0] ADR_HI      = 2'b00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_b,
    input  logic                  rnw,
    input  logic [CPU_ADR_W-1:0]  address,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  ready,
    output logic [SRAM_ADR_W-1:0] ram_adr,
    output logic                  ram_cs_b,
    output logic                  ram_oe_b,
    output logic                  ram_we_b,
    output logic [DATA_W-1:0]     dat_out,
    output logic                  dat_oe,
    input  logic [DATA_W-1:0]     dat_in
);

    // Counter holds WAIT_STATES-1 on the first ACCESS cycle, so zero marks the last one.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES - 1);

    bridge_state_t state;
    logic          rnw_q;
    logic          wait_zero;

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (state == ST_SETUP),
        .dec        (state == ST_ACCESS),
        .load_value (WAIT_LOAD),
        .zero       (wait_zero)
    );

    assign ready = (state == ST_DONE) || ((state == ST_IDLE) && cs_b);

    // Outputs are assigned for the state being entered, so every SRAM pin comes from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rnw_q    <= 1'b1;
            dout     <= '0;
            ram_adr  <= sram_adr(ADR_HI, '0);
            dat_out  <= '0;
            dat_oe   <= 1'b0;
            ram_cs_b <= 1'b1;
            ram_oe_b <= 1'b1;
            ram_we_b <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs_b) begin
                        rnw_q    <= rnw;
                        ram_adr  <= sram_adr(ADR_HI, address);
                        dat_out  <= din;
                        ram_cs_b <= 1'b0;
                        ram_oe_b <= !rnw;
                        ram_we_b <= 1'b1;
                        dat_oe   <= !rnw;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!rnw_q) begin
                        ram_we_b <= 1'b0;
                    end
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wait_zero) begin
                        if (rnw_q) begin
                            dout     <= dat_in;
                            ram_cs_b <= 1'b1;
                            ram_oe_b <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            ram_we_b <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    ram_cs_b <= 1'b1;
                    dat_oe   <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    ram_cs_b <= 1'b1;
                    ram_oe_b <= 1'b1;
                    ram_we_b <= 1'b1;
                    dat_oe   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb/tb_sram_bus_bridge.sv - randomized self-checking bench for sram_bus_bridge
module tb_sram_bus_bridge;

    localparam int         WS  = 2;
    localparam logic [1:0] AHI = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_b, rnw;
    logic [15:0] address, din, dat_in, dout, dat_out;
    logic        ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe;
    logic [17:0] ram_adr;

    logic        cs_b1, rnw1;
    logic [15:0] address1, din1, dat_in1, dout1, dat_out1;
    logic        ready1, ram_cs_b1, ram_oe_b1, ram_we_b1, dat_oe1;
    logic [17:0] ram_adr1;

    int          total = 0;
    int          bad = 0;
    logic [15:0] model_dout = 16'h0000;
    bit          b2b_pending = 0;

    always #5 clk = ~clk;

    sram_bus_bridge #(.WAIT_STATES(WS), .ADR_HI(AHI)) dut (
        .clk(clk), .reset(reset), .cs_b(cs_b), .rnw(rnw), .address(address), .din(din),
        .dout(dout), .ready(ready), .ram_adr(ram_adr), .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b),
        .ram_we_b(ram_we_b), .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in)
    );

    sram_bus_bridge dut1 (
        .clk(clk), .reset(reset), .cs_b(cs_b1), .rnw(rnw1), .address(address1), .din(din1),
        .dout(dout1), .ready(ready1), .ram_adr(ram_adr1), .ram_cs_b(ram_cs_b1), .ram_oe_b(ram_oe_b1),
        .ram_we_b(ram_we_b1), .dat_out(dat_out1), .dat_oe(dat_oe1), .dat_in(dat_in1)
    );

    // One access on the main instance; expected pin windows come from the latency rules.
    task automatic do_access(input bit r, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] rd, input bit keep_low);
        int          lat;
        logic [17:0] exp_adr;
        logic [4:0]  exp_pins;
        lat     = r ? WS + 2 : WS + 3;
        exp_adr = {AHI, a};
        if (!b2b_pending) begin
            @(negedge clk);
            total++;
            if (ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_ready got=%b exp=1", ready);
            end
        end
        cs_b = 1'b0; rnw = r; address = a; din = d; dat_in = rd;
        if (b2b_pending) @(negedge clk);
        else #1;
        total++;
        if ({ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe} !== 5'b01110) begin
            bad++;
            $display("FAIL cycle0_pins got=%b exp=01110", {ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe});
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            exp_pins[4] = (c == lat);
            exp_pins[3] = !(c < lat);
            exp_pins[2] = !(r && c < lat);
            exp_pins[1] = !(!r && c >= 2 && c <= WS + 1);
            exp_pins[0] = !r && c < lat;
            total++;
            if ({ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe} !== exp_pins) begin
                bad++;
                $display("FAIL pins rnw=%0d cyc=%0d got=%b exp=%b", r, c,
                         {ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe}, exp_pins);
            end
            if (c < lat) begin
                total++;
                if (ram_adr !== exp_adr) begin
                    bad++;
                    $display("FAIL ram_adr cyc=%0d got=%h exp=%h", c, ram_adr, exp_adr);
                end
            end
            if (!r && c < lat) begin
                total++;
                if (dat_out !== d) begin
                    bad++;
                    $display("FAIL dat_out cyc=%0d got=%h exp=%h", c, dat_out, d);
                end
            end
            total++;
            if ((!ram_we_b && !ram_oe_b) || (dat_oe && !ram_oe_b)) begin
                bad++;
                $display("FAIL contention cyc=%0d we_b=%b oe_b=%b dat_oe=%b", c, ram_we_b, ram_oe_b, dat_oe);
            end
            if (c == lat && r) model_dout = rd;
            total++;
            if (dout !== model_dout) begin
                bad++;
                $display("FAIL dout cyc=%0d got=%h exp=%h", c, dout, model_dout);
            end
            if (c < lat) begin
                address = 16'($urandom);
                din     = 16'($urandom);
                rnw     = 1'($urandom);
                cs_b    = 1'($urandom);
                if (!r) dat_in = 16'($urandom);
            end else begin
                cs_b = keep_low ? 1'b0 : 1'b1;
            end
        end
        b2b_pending = keep_low;
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_b = 1'b1; rnw = 1'b1; address = 16'h5555; din = 16'hAAAA; dat_in = 16'h0;
        cs_b1 = 1'b1; rnw1 = 1'b1; address1 = 16'h0; din1 = 16'h0; dat_in1 = 16'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe} !== 5'b11110 || dout !== 16'h0 ||
            ram_adr !== {AHI, 16'h0000} || dat_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_state pins=%b dout=%h adr=%h dat_out=%h", {ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe},
                     dout, ram_adr, dat_out);
        end
        cs_b = 1'b0; #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_cs_low got=%b exp=0", ready);
        end
        cs_b = 1'b1; #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_ws1();
        @(negedge clk);
        cs_b1 = 1'b0; rnw1 = 1'b1; address1 = 16'h0123; dat_in1 = 16'hA55A; #1;
        total++;
        if (ready1 !== 1'b0) begin
            bad++;
            $display("FAIL ws1_cycle0_ready got=%b exp=0", ready1);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cs_b1 = 1'b1; address1 = 16'($urandom);
            total++;
            if (ram_oe_b1 !== (c == 3) || ready1 !== (c == 3) || ram_we_b1 !== 1'b1) begin
                bad++;
                $display("FAIL ws1_pins cyc=%0d oe_b=%b ready=%b we_b=%b", c, ram_oe_b1, ready1, ram_we_b1);
            end
            if (c < 3) begin
                total++;
                if (ram_adr1 !== 18'h00123) begin
                    bad++;
                    $display("FAIL ws1_adr cyc=%0d got=%h exp=00123", c, ram_adr1);
                end
            end
        end
        total++;
        if (dout1 !== 16'hA55A) begin
            bad++;
            $display("FAIL ws1_dout got=%h exp=a55a", dout1);
        end
    endtask

    task automatic test_idle();
        cs_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            address = 16'($urandom); din = 16'($urandom); rnw = 1'($urandom);
            total++;
            if ({ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe} !== 5'b11110) begin
                bad++;
                $display("FAIL idle_pins i=%0d got=%b exp=11110", i, {ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe});
            end
        end
    endtask

    task automatic test_literal();
        do_access(1'b0, 16'hFFFE, 16'h1234, 16'h0, 1'b0);
        do_access(1'b1, 16'h0123, 16'h0, 16'hA55A, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 16'h00F0, 16'hBEEF, 16'h0, 1'b1);
        do_access(1'b1, 16'h00F0, 16'h0, 16'h4321, 1'b1);
        do_access(1'b1, 16'h7777, 16'h0, 16'h8888, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        cs_b = 1'b0; rnw = 1'b0; address = 16'h3C3C; din = 16'h9999;
        repeat (2) @(negedge clk);
        total++;
        if (ram_we_b !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_we got=%b exp=0", ram_we_b);
        end
        reset = 1'b1; #1;
        total++;
        if ({ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe} !== 5'b01110 || dout !== 16'h0 ||
            ram_adr !== {AHI, 16'h0000} || dat_out !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset pins=%b dout=%h adr=%h dat_out=%h", {ready, ram_cs_b, ram_oe_b, ram_we_b, dat_oe},
                     dout, ram_adr, dat_out);
        end
        model_dout = 16'h0;
        cs_b = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b2b_pending = 0;
        do_access(1'b1, 16'h1111, 16'h0, 16'h2468, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_access(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end
        if (b2b_pending) do_access(1'b1, 16'h0, 16'h0, 16'h5A5A, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_ws1();
        test_idle();
        test_literal();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
